// File: rtl/branch_pc_unit.sv
// Registered PC, flag register and return-address stack with condition evaluation.
// Optional BRANCH_SIGNED_CMP_EN selects signed (N^V) less-than instead of the plain sign test.
module branch_pc_unit #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flags_we,
  input  logic                alu_z,
  input  logic                alu_n,
  input  logic                alu_c,
  input  logic                alu_v,
  input  logic                is_jump,
  input  logic                is_call,
  input  logic                is_ret,
  input  logic [3:0]          jump_cond,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                jump_taken,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_c,
  output logic                flag_v,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                stack_err
);

  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PtrW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(STACK_DEPTH);

  typedef enum logic [3:0] {
    CcJmp = 4'b0000,
    CcJeq = 4'b0001,
    CcJne = 4'b0010,
    CcJgt = 4'b0011,
    CcJge = 4'b0100,
    CcJlt = 4'b0101,
    CcJle = 4'b0110,
    CcJcs = 4'b0111,
    CcJvs = 4'b1000
  } cond_e;

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [CntW-1:0]     count_q, count_d, count_m1;
  logic                err_q, err_d;
  logic                z_q, n_q, c_q, v_q;
  logic                push;
  logic                lt;
  logic                cond_met;
  logic [PtrW-1:0]     wr_ptr, rd_ptr;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  assign pc_inc   = pc_q + PC_WIDTH'(1);
  assign count_m1 = count_q - CntW'(1);
  assign wr_ptr   = count_q[PtrW-1:0];
  assign rd_ptr   = count_m1[PtrW-1:0];

  assign stack_full  = (count_q == DepthC);
  assign stack_empty = (count_q == '0);

`ifdef BRANCH_SIGNED_CMP_EN
  assign lt = n_q ^ v_q;
`else
  assign lt = n_q;
`endif

  // Conditions look only at registered flags; a same-cycle flag write is not bypassed.
  always_comb begin
    cond_met = 1'b0;
    case (cond_e'(jump_cond))
      CcJmp:   cond_met = 1'b1;
      CcJeq:   cond_met = z_q;
      CcJne:   cond_met = ~z_q;
      CcJgt:   cond_met = ~lt & ~z_q;
      CcJge:   cond_met = ~lt;
      CcJlt:   cond_met = lt;
      CcJle:   cond_met = lt | z_q;
      CcJcs:   cond_met = c_q;
      CcJvs:   cond_met = v_q;
      default: cond_met = 1'b0;
    endcase
  end

  // Priority ret > call > jump when several are (illegally) asserted together.
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    err_d      = err_q;
    push       = 1'b0;
    jump_taken = 1'b0;
    if (!stall) begin
      pc_d = pc_inc;
      if (is_ret) begin
        if (stack_empty) begin
          err_d = 1'b1;
        end else begin
          pc_d       = stack_q[rd_ptr];
          count_d    = count_m1;
          jump_taken = 1'b1;
        end
      end else if (is_call) begin
        pc_d       = target;
        jump_taken = 1'b1;
        if (stack_full) begin
          err_d = 1'b1;
        end else begin
          push    = 1'b1;
          count_d = count_q + CntW'(1);
        end
      end else if (is_jump && cond_met) begin
        pc_d       = target;
        jump_taken = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      if (flags_we && !stall) begin
        z_q <= alu_z;
        n_q <= alu_n;
        c_q <= alu_c;
        v_q <= alu_v;
      end
    end
  end

  // Entries above the count are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      stack_q[wr_ptr] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_c    = c_q;
  assign flag_v    = v_q;
  assign stack_err = err_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed self-checking bench for branch_pc_unit (PC_WIDTH=8, STACK_DEPTH=4).
module tb_branch_pc_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, flags_we;
  logic       alu_z, alu_n, alu_c, alu_v;
  logic       is_jump, is_call, is_ret;
  logic [3:0] jump_cond;
  logic [7:0] target;
  logic [7:0] pc;
  logic       jump_taken;
  logic       flag_z, flag_n, flag_c, flag_v;
  logic       stack_full, stack_empty, stack_err;

  int checks   = 0;
  int failures = 0;

`ifdef BRANCH_SIGNED_CMP_EN
  localparam logic JltExp = 1'b0;
`else
  localparam logic JltExp = 1'b1;
`endif

  branch_pc_unit #(
    .PC_WIDTH   (8),
    .STACK_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flags_we   (flags_we),
    .alu_z      (alu_z),
    .alu_n      (alu_n),
    .alu_c      (alu_c),
    .alu_v      (alu_v),
    .is_jump    (is_jump),
    .is_call    (is_call),
    .is_ret     (is_ret),
    .jump_cond  (jump_cond),
    .target     (target),
    .pc         (pc),
    .jump_taken (jump_taken),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flags_we = 1'b0;
    is_jump  = 1'b0;
    is_call  = 1'b0;
    is_ret   = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    alu_z = 1'b0; alu_n = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    jump_cond = 4'd0; target = 8'd0;
    idle();
    #12;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h0);
    chk("rst_empty", 32'(stack_empty), 32'h1);
    chk("rst_full", 32'(stack_full), 32'h0);
    chk("rst_err", 32'(stack_err), 32'h0);
    rst = 1'b0;

    // free run
    tick(); chk("run_pc1", 32'(pc), 32'h1);
    tick(); chk("run_pc2", 32'(pc), 32'h2);
    tick(); chk("run_pc3", 32'(pc), 32'h3);

    // wrap from 255
    is_jump = 1'b1; jump_cond = 4'd0; target = 8'hff;
    #1 chk("jmp_255_jt", 32'(jump_taken), 32'h1);
    tick(); chk("pc_255", 32'(pc), 32'hff);
    idle();
    tick(); chk("wrap_pc0", 32'(pc), 32'h0);

    // JEQ in same cycle as flag write sees old Z=0
    flags_we = 1'b1; alu_z = 1'b1;
    is_jump = 1'b1; jump_cond = 4'd1; target = 8'h40;
    #1 chk("jeq_old_flag_jt", 32'(jump_taken), 32'h0);
    tick(); chk("jeq_old_pc", 32'(pc), 32'h1);
    chk("flag_z_set", 32'(flag_z), 32'h1);
    flags_we = 1'b0;
    #1 chk("jeq_jt", 32'(jump_taken), 32'h1);
    tick(); chk("jeq_pc", 32'(pc), 32'h40);

    // JNE with Z=1, then JMP
    jump_cond = 4'd2; target = 8'h22;
    #1 chk("jne_jt", 32'(jump_taken), 32'h0);
    tick(); chk("jne_pc", 32'(pc), 32'h41);
    jump_cond = 4'd0; target = 8'h10;
    #1 chk("jmp_jt", 32'(jump_taken), 32'h1);
    tick(); chk("jmp_pc", 32'(pc), 32'h10);

    // N=1 V=1 Z=0
    idle();
    flags_we = 1'b1; alu_z = 1'b0; alu_n = 1'b1; alu_v = 1'b1; alu_c = 1'b0;
    tick(); chk("flags_nv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h5);
    chk("flags_pc", 32'(pc), 32'h11);
    flags_we = 1'b0;
    is_jump = 1'b1; jump_cond = 4'd5; target = 8'h30;
    #1 chk("jlt_jt", 32'(jump_taken), 32'(JltExp));
    jump_cond = 4'd8;
    #1 chk("jvs_jt", 32'(jump_taken), 32'h1);
    jump_cond = 4'd7;
    #1 chk("jcs_jt", 32'(jump_taken), 32'h0);
    jump_cond = 4'd9;
    #1 chk("cc9_jt", 32'(jump_taken), 32'h0);
    jump_cond = 4'd5;
    tick(); chk("jlt_pc", 32'(pc), JltExp ? 32'h30 : 32'h12);
    jump_cond = 4'd0; target = 8'h05;
    tick(); chk("to5_pc", 32'(pc), 32'h05);

    // CALL then RET
    idle();
    is_call = 1'b1; target = 8'h20;
    #1 chk("call_jt", 32'(jump_taken), 32'h1);
    tick(); chk("call_pc", 32'(pc), 32'h20);
    chk("call_nonempty", 32'(stack_empty), 32'h0);
    is_call = 1'b0; is_ret = 1'b1;
    #1 chk("ret_jt", 32'(jump_taken), 32'h1);
    tick(); chk("ret_pc", 32'(pc), 32'h06);
    chk("ret_empty", 32'(stack_empty), 32'h1);

    // four nested calls fill the stack
    is_ret = 1'b0; is_call = 1'b1;
    target = 8'h50; tick(); chk("nest1_pc", 32'(pc), 32'h50);
    target = 8'h60; tick(); chk("nest2_pc", 32'(pc), 32'h60);
    target = 8'h70; tick(); chk("nest3_pc", 32'(pc), 32'h70);
    chk("nest3_full", 32'(stack_full), 32'h0);
    target = 8'h80; tick(); chk("nest4_pc", 32'(pc), 32'h80);
    chk("nest4_full", 32'(stack_full), 32'h1);
    chk("nest4_err", 32'(stack_err), 32'h0);
    target = 8'h90;
    #1 chk("ovf_jt", 32'(jump_taken), 32'h1);
    tick(); chk("ovf_pc", 32'(pc), 32'h90);
    chk("ovf_err", 32'(stack_err), 32'h1);
    chk("ovf_full", 32'(stack_full), 32'h1);

    // LIFO unwinding
    is_call = 1'b0; is_ret = 1'b1;
    tick(); chk("pop1_pc", 32'(pc), 32'h71);
    tick(); chk("pop2_pc", 32'(pc), 32'h61);
    tick(); chk("pop3_pc", 32'(pc), 32'h51);
    tick(); chk("pop4_pc", 32'(pc), 32'h07);
    chk("pop4_empty", 32'(stack_empty), 32'h1);

    // stall freezes everything
    idle();
    stall = 1'b1; is_jump = 1'b1; jump_cond = 4'd0; target = 8'h33;
    flags_we = 1'b1; alu_c = 1'b1;
    #1 chk("stall_jt", 32'(jump_taken), 32'h0);
    tick(); chk("stall_pc", 32'(pc), 32'h07);
    chk("stall_flag_c", 32'(flag_c), 32'h0);
    idle();
    tick(); chk("unstall_pc", 32'(pc), 32'h08);

    // async reset during a CALL
    is_call = 1'b1; target = 8'h99;
    #1 rst = 1'b1;
    #1 chk("mid_rst_pc", 32'(pc), 32'h0);
    chk("mid_rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'h0);
    chk("mid_rst_err", 32'(stack_err), 32'h0);
    chk("mid_rst_empty", 32'(stack_empty), 32'h1);
    tick(); chk("mid_rst_hold_pc", 32'(pc), 32'h0);
    chk("mid_rst_hold_empty", 32'(stack_empty), 32'h1);
    idle();
    rst = 1'b0;

    // RET on empty stack
    is_ret = 1'b1;
    #1 chk("uf_jt", 32'(jump_taken), 32'h0);
    tick(); chk("uf_pc", 32'(pc), 32'h1);
    chk("uf_err", 32'(stack_err), 32'h1);
    idle();
    tick(); chk("uf_err_sticky", 32'(stack_err), 32'h1);
    chk("uf_pc2", 32'(pc), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
